// File: rtl/hack_cpu_seq.sv
// hack_cpu_seq: multi-cycle Hack CPU sequencer (FETCH/EXEC/WRITE) around an external 16-bit Hack ALU.
// Optional HACK_HALT_EN adds halt_req/halted and a HALT state.
`default_nettype none

module hack_cpu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [14:0] pc,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  input  logic [15:0] inM,
  output logic [14:0] addressM,
  output logic [15:0] outM,
  output logic        writeM
`ifdef HACK_HALT_EN
  ,
  input  logic        halt_req,
  output logic        halted
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
`ifdef HACK_HALT_EN
    ,
    HALT  = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [15:0] ir;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic        rzr;
  logic        rng;
  logic        jump;

  assign alu_x    = d_reg;
  assign alu_y    = ir[12] ? inM : a_reg;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir[11:6];
  assign addressM = a_reg[14:0];
  assign jump     = (ir[2] & rng) | (ir[1] & rzr) | (ir[0] & ~rzr & ~rng);

`ifdef HACK_HALT_EN
  assign instr_ready = (state == FETCH) & ~reset & ~halt_req;
`else
  assign instr_ready = (state == FETCH) & ~reset;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      ir     <= 16'h0000;
      a_reg  <= 16'h0000;
      d_reg  <= 16'h0000;
      pc     <= 15'h0000;
      outM   <= 16'h0000;
      rzr    <= 1'b0;
      rng    <= 1'b0;
      writeM <= 1'b0;
`ifdef HACK_HALT_EN
      halted <= 1'b0;
`endif
    end else begin
      writeM <= 1'b0;
      case (state)
        FETCH: begin
`ifdef HACK_HALT_EN
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else
`endif
          if (instr_valid) begin
            ir    <= instr;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!ir[15]) begin
            a_reg <= {1'b0, ir[14:0]};
            pc    <= pc + 15'd1;
            state <= FETCH;
          end else begin
            outM   <= alu_out;
            rzr    <= alu_zr;
            rng    <= alu_ng;
            writeM <= ir[3];
            state  <= WRITE;
          end
        end
        WRITE: begin
          // a_reg still holds the old A here, so jump target and M address use it
          if (ir[4]) d_reg <= outM;
          if (ir[5]) a_reg <= outM;
          pc    <= jump ? a_reg[14:0] : pc + 15'd1;
          state <= FETCH;
        end
`ifdef HACK_HALT_EN
        HALT: begin
          if (!halt_req) begin
            state  <= FETCH;
            halted <= 1'b0;
          end
        end
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hack_cpu_seq.sv
// tb_hack_cpu_seq: scoreboard bench for hack_cpu_seq with a behavioural Hack ALU and data memory.
`default_nettype none

module tb_hack_cpu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [14:0] pc;
  logic [15:0] alu_x, alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic [15:0] inM;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
`ifdef HACK_HALT_EN
  logic        halt_req;
  logic        halted;
`endif

  int tests  = 0;
  int errors = 0;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [15:0] mem  [0:255];
  logic [15:0] mmem [0:255];
  logic [15:0] ma, md;
  logic [14:0] mpc;

  always #5 clk = ~clk;

  hack_cpu_seq dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out), .alu_zr(alu_zr),
    .alu_ng(alu_ng), .inM(inM), .addressM(addressM), .outM(outM), .writeM(writeM)
`ifdef HACK_HALT_EN
    , .halt_req(halt_req), .halted(halted)
`endif
  );

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xa, ya, o;
    xa = c[5] ? 16'h0000 : x;
    if (c[4]) xa = ~xa;
    ya = c[3] ? 16'h0000 : y;
    if (c[2]) ya = ~ya;
    o = c[1] ? xa + ya : xa & ya;
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  assign alu_zr  = (alu_out == 16'h0000);
  assign alu_ng  = alu_out[15];
  assign inM     = mem[addressM[7:0]];

  always @(posedge clk) if (writeM) mem[addressM[7:0]] <= outM;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every observed write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && writeM) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", {17'd0, addressM}, {17'd0, w.addr});
        check("wr_data", {16'd0, outM}, {16'd0, w.data});
      end
    end
  end

  task automatic model_reset();
    ma  = 16'h0000;
    md  = 16'h0000;
    mpc = 15'h0000;
  endtask

  // Called at a negedge; returns at the negedge where the DUT is back in FETCH
  task automatic issue(input logic [15:0] ins);
    int n;
    logic [15:0] y, r;
    logic jmp, zr, ng;
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    check("fetch_pc", {17'd0, pc}, {17'd0, mpc});
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    y = ins[12] ? mmem[ma[7:0]] : ma;
    if (ins[15]) begin
      check("alu_x", {16'd0, alu_x}, {16'd0, md});
      check("alu_y", {16'd0, alu_y}, {16'd0, y});
      check("alu_ctl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, {26'd0, ins[11:6]});
      r   = hack_alu(md, y, ins[11:6]);
      zr  = (r == 16'h0000);
      ng  = r[15];
      jmp = (ins[2] & ng) | (ins[1] & zr) | (ins[0] & ~zr & ~ng);
      if (ins[3]) begin
        exp_q.push_back({ma[14:0], r});
        mmem[ma[7:0]] = r;
      end
      mpc = jmp ? ma[14:0] : mpc + 15'd1;
      if (ins[5]) ma = r;
      if (ins[4]) md = r;
    end else begin
      ma  = {1'b0, ins[14:0]};
      mpc = mpc + 15'd1;
    end
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    check("latency", n, ins[15] ? 32'd2 : 32'd1);
    check("pc", {17'd0, pc}, {17'd0, mpc});
    check("addressM", {17'd0, addressM}, {17'd0, ma[14:0]});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'h0000;
      mmem[i] = 16'h0000;
    end
    model_reset();
    reset       = 1'b1;
    instr       = 16'h0000;
    instr_valid = 1'b0;
`ifdef HACK_HALT_EN
    halt_req    = 1'b0;
`endif
    #1;
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_writeM", {31'd0, writeM}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_pc", {17'd0, pc}, 32'd0);
    check("rst_addr", {17'd0, addressM}, 32'd0);
    check("rst_outM", {16'd0, outM}, 32'd0);
    check("rst_ready_rel", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);

    // @5; D=A
    issue(16'h0005);
    issue(16'hEC10);
    // @100; M=D; then D=M reads it back through inM
    issue(16'h0064);
    issue(16'hE308);
    issue(16'hFC10);
    // @10; 0;JMP
    issue(16'h000A);
    issue(16'hEA87);
    // D=0 via @0; D=A, then D;JGT must not jump
    issue(16'h0000);
    issue(16'hEC10);
    issue(16'hE301);

    // idle in FETCH
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, instr_ready}, 32'd1);
      check("idle_pc", {17'd0, pc}, {17'd0, mpc});
      check("idle_addr", {17'd0, addressM}, {17'd0, ma[14:0]});
    end

    // @7; D=A; @20; AM=D+1;JMP  -> jump and write both use old A
    issue(16'h0007);
    issue(16'hEC10);
    issue(16'h0014);
    issue(16'hE7EF);

    // pc wrap: jump to 0x7FFF, then one A-instruction
    issue(16'h7FFF);
    issue(16'hEA87);
    issue(16'h0001);

    // reset in the WRITE cycle of M=D
    issue(16'h0009);
    issue(16'hEC10);
    issue(16'h0032);
    instr = 16'hE308;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #2;
    check("wm_pre_rst", {31'd0, writeM}, 32'd1);
    reset = 1'b1;
    #1;
    check("wm_rst_drop", {31'd0, writeM}, 32'd0);
    check("rst2_pc", {17'd0, pc}, 32'd0);
    check("rst2_addr", {17'd0, addressM}, 32'd0);
    check("rst2_outM", {16'd0, outM}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    issue(16'h0003);
    issue(16'hEC10);

`ifdef HACK_HALT_EN
    halt_req    = 1'b1;
    instr       = 16'h0011;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halted", {31'd0, halted}, 32'd1);
      check("halt_ready", {31'd0, instr_ready}, 32'd0);
      check("halt_pc", {17'd0, pc}, {17'd0, mpc});
      check("halt_addr", {17'd0, addressM}, {17'd0, ma[14:0]});
    end
    halt_req = 1'b0;
    issue(16'h0011);
    check("unhalted", {31'd0, halted}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("wr_pending", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/hack_cpu_seq.md
# hack_cpu_seq

Multi-cycle Hack CPU sequencer that drives the 16-bit Hack ALU (zx, nx, zy, ny, f, no) and consumes its result and flags. It fetches one instruction at a time over a valid/ready handshake, owns the A, D and PC registers, and issues data-memory writes. The block sits directly upstream of the ALU, which supplies the operation, and directly downstream of it, which commits the result and resolves jumps.

## Interface
- No parameters; the data width is fixed at 16 bits and the address width at 15 bits.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  16  instruction word from the instruction source.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  sequencer accepts an instruction this cycle.
- pc  out  15  address of the instruction being fetched.
- alu_x, alu_y  out  16  ALU operands: alu_x = D; alu_y = ir[12] ? inM : A.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1  ALU controls, equal to ir[11:6] in that order.
- alu_out  in  16  ALU result.
- alu_zr, alu_ng  in  1  ALU zero and negative flags.
- inM  in  16  data-memory read data, combinational on addressM.
- addressM  out  15  data-memory address; always A[14:0].
- outM  out  16  write data; the registered ALU result.
- writeM  out  1  data-memory write strobe, asserted for one cycle.

## Operation
- The FSM has three states: FETCH, EXEC and WRITE. Reset state is FETCH.
- **FETCH**
  - instr_ready = 1 (forced to 0 while reset is high).
  - On instr_valid & instr_ready: ir <= instr, then go to EXEC.
  - Otherwise hold, with pc stable.
- **EXEC, A-instruction** (ir[15] = 0):
  - A <= {1'b0, ir[14:0]}, pc <= pc + 1, then go to FETCH.
  - ALU results are ignored.
- **EXEC, C-instruction** (ir[15] = 1):
  - The ALU controls and operands are driven from ir.
  - At the clock edge: res <= alu_out, rzr <= alu_zr, rng <= alu_ng, then go to WRITE.
- **WRITE**
  - writeM = ir[3]; addressM uses the A value from before the update; outM = res.
  - if ir[4]: D <= res.
  - if ir[5]: A <= res.
  - jump = (ir[2] & rng) | (ir[1] & rzr) | (ir[0] & ~rzr & ~rng).
  - pc <= jump ? A_old[14:0] : pc + 1.
  - Go to FETCH.
- When dest includes both A and a jump, the jump target is the old A.
- When dest includes both A and M, the M address is the old A.
- pc wraps from 0x7FFF to 0x0000 with no error.
- ir[14:13] are ignored.
- The ALU controls and operands are valid only in EXEC. In other states they follow ir and must be treated as don't-care.

## Timing
- Reset values: A, D, pc, ir, res, rzr, rng, outM all = 0; writeM = 0; instr_ready = 0 while reset is high; FSM = FETCH.
- An A-instruction takes 2 cycles from acceptance; a C-instruction takes 3. Wait cycles for instr_valid are added on top.
- The ALU path is combinational within EXEC. inM must settle within EXEC for addressM = A.
- writeM is high for exactly the WRITE cycle of a C-instruction with ir[3] = 1, and never otherwise.
- Reset asserted in any state:
  - All registers clear immediately.
  - An in-flight write is dropped: writeM falls asynchronously.
  - After reset deasserts, fetch resumes at pc = 0.
- instr_valid asserted outside FETCH is ignored, and the instruction is not consumed.

## Configuration
- **HACK_HALT_EN defined**
  - Adds input halt_req (1 bit) and output halted (1 bit), plus state HALT.
  - In FETCH, halt_req = 1 takes priority over instr_valid: no instruction is accepted and the FSM goes to HALT.
  - In HALT: instr_ready = 0, halted = 1, all registers hold.
  - The FSM returns to FETCH the cycle after halt_req = 0.
  - halted resets to 0.
- **HACK_HALT_EN undefined**
  - halt_req, halted and HALT are not present; behaviour is exactly as above.

## Test plan
- Reset, then feed 0x0005 (@5) and 0xEC10 (D=A). Required: A = 5, D = 5, pc = 2; writeM never asserted; 5 cycles total.
- With D = 5, feed 0x0064 (@100) and 0xE308 (M=D). Required: a single writeM pulse with addressM = 100 and outM = 5; pc = next address; D unchanged.
- Feed 0x000A (@10) and 0xEA87 (0;JMP). Required: pc = 10 after WRITE. Then, with D = 0, feed 0xE301 (D;JGT). Required: no jump, pc increments.
- Hold instr_valid low for 8 cycles in FETCH. Required: instr_ready = 1 throughout; pc, A, D stable; no writeM.
- Assert reset during the WRITE of an M=D instruction. Required: writeM drops within the same cycle; A = D = pc = 0; the next accepted instruction is fetched from pc = 0.
- With HACK_HALT_EN, assert halt_req in FETCH while instr_valid = 1. Required: halted = 1, instr_ready = 0, the instruction is not consumed. Release halt_req. Required: the same instruction is accepted next.
